// File: rtl/reset_sequencer.sv
// reset_sequencer: releases per-stage resets in order, each gated by its ack or a tick-based timeout.
module reset_sequencer #(
  parameter int STAGES      = 4,
  parameter int TICK_DIV    = 65536,
  parameter int HOLD_TICKS  = 2,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              reset_req,
  input  logic [STAGES-1:0] stage_ack,
  output logic [STAGES-1:0] stage_reset,
  output logic              all_ready,
  output logic              timeout_err,
  output logic [2:0]        fault_stage
);
  localparam int PW = $clog2(TICK_DIV);
  typedef enum logic [1:0] {HOLD, RELEASE, WAIT_ACK, READY} state_t;
  state_t state, state_n;
  logic [PW-1:0] pre;
  logic [7:0] tcnt, tcnt_n, tinc;
  logic [2:0] idx, idx_n, fault_n;
  logic [STAGES-1:0] sel, sr_n;
  logic tick, acked, expired, adv, last, err_n;
  assign tick    = pre == PW'(TICK_DIV - 1);
  assign tinc    = tcnt == 8'hff ? tcnt : tcnt + 8'd1;
  assign sel     = STAGES'(1) << idx;
  assign acked   = |(stage_ack & sel);
  assign expired = tick && tinc == 8'(ACK_TIMEOUT);
  assign adv     = state == WAIT_ACK && (acked || expired);
  assign last    = idx == 3'(STAGES - 1);
  always_comb begin
    state_n = state;
    idx_n   = idx;
    tcnt_n  = tcnt;
    sr_n    = stage_reset;
    err_n   = timeout_err;
    fault_n = fault_stage;
    if (reset_req) begin
      state_n = HOLD;
      idx_n   = '0;
      tcnt_n  = '0;
      sr_n    = '1;
      err_n   = 1'b0;
      fault_n = '0;
    end else begin
      case (state)
        HOLD: begin
          tcnt_n  = tick ? tinc : tcnt;
          state_n = tick && tinc == 8'(HOLD_TICKS) ? RELEASE : HOLD;
          idx_n   = '0;
        end
        RELEASE: begin
          sr_n    = stage_reset & ~sel;
          tcnt_n  = '0;
          state_n = WAIT_ACK;
        end
        WAIT_ACK: begin
          tcnt_n  = !acked && tick ? tinc : tcnt;
          // an ack sampled on the expiry edge wins, so no error is logged then
          err_n   = timeout_err | (!acked && expired);
          fault_n = !acked && expired && !timeout_err ? idx : fault_stage;
          state_n = adv ? (last ? READY : RELEASE) : WAIT_ACK;
          idx_n   = adv && !last ? idx + 3'd1 : idx;
        end
        READY: state_n = READY;
        default: state_n = HOLD;
      endcase
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= HOLD;
      pre         <= '0;
      tcnt        <= '0;
      idx         <= '0;
      stage_reset <= '1;
      all_ready   <= 1'b0;
      timeout_err <= 1'b0;
      fault_stage <= '0;
    end else begin
      state       <= state_n;
      pre         <= tick ? '0 : pre + PW'(1);
      tcnt        <= tcnt_n;
      idx         <= idx_n;
      stage_reset <= sr_n;
      all_ready   <= state_n == READY;
      timeout_err <= err_n;
      fault_stage <= fault_n;
    end
  end
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: event-time reference model checking release order, timeouts, aborts and reset priority.
module tb_reset_sequencer;
  localparam int N = 4, DIV = 4, HOLD = 2, TMO = 3;
  logic clock = 0, reset = 1, reset_req = 0;
  logic [N-1:0] stage_ack = '0;
  logic [N-1:0] stage_reset;
  logic all_ready, timeout_err;
  logic [2:0] fault_stage;
  int total = 0, bad = 0, cyc = 0;
  int a[N], R[N], D[N];
  bit TO[N];

  reset_sequencer #(.STAGES(N), .TICK_DIV(DIV), .HOLD_TICKS(HOLD), .ACK_TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset), .reset_req(reset_req), .stage_ack(stage_ack),
    .stage_reset(stage_reset), .all_ready(all_ready), .timeout_err(timeout_err),
    .fault_stage(fault_stage)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= reset ? 0 : cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Ticks are counted on edges that are positive multiples of DIV since reset.
  // Stage k releases at edge R[k]; its decision edge D[k] is its ack edge or the
  // TMO-th tick edge after R[k], whichever is first (ack wins on a tie).
  task automatic plan(input int f);
    int r, t, ack;
    r = ((f + DIV - 1) / DIV) * DIV + DIV * (HOLD - 1) + 1;
    for (int k = 0; k < N; k++) begin
      t = (r / DIV + 1) * DIV + DIV * (TMO - 1);
      ack = a[k] == 0 ? 1 << 30 : r + a[k];
      R[k] = r;
      D[k] = ack <= t ? ack : t;
      TO[k] = ack > t;
      r = D[k] + 1;
    end
  endtask

  task automatic run_seq(input string name, input int abort_e);
    logic [N-1:0] esr;
    bit eerr;
    int ef, last;
    plan(cyc + 1);
    last = D[N-1] + 3;
    for (int e = cyc + 1; e <= last; e++) begin
      for (int k = 0; k < N; k++)
        stage_ack[k] = e > D[N-1] ? 1'($urandom) : (a[k] != 0 && e >= R[k] + a[k]);
      reset_req = e == abort_e;
      @(posedge clock); #1;
      if (e == abort_e) begin
        total++;
        if ({stage_reset, all_ready, timeout_err, fault_stage} !== {{N{1'b1}}, 5'b0}) begin
          bad++;
          $display("FAIL %s abort e=%0d got sr=%b rdy=%b err=%b fs=%0d exp sr=1111 rdy=0 err=0 fs=0",
                   name, e, stage_reset, all_ready, timeout_err, fault_stage);
        end
        reset_req = 0;
        return;
      end
      esr = '1; eerr = 0; ef = 0;
      for (int k = 0; k < N; k++) begin
        if (e >= R[k]) esr[k] = 1'b0;
        if (TO[k] && e >= D[k] && !eerr) begin eerr = 1; ef = k; end
      end
      total++;
      if (stage_reset !== esr) begin
        bad++; $display("FAIL %s stage_reset e=%0d got=%b exp=%b", name, e, stage_reset, esr);
      end
      total++;
      if (all_ready !== (e >= D[N-1])) begin
        bad++; $display("FAIL %s all_ready e=%0d got=%b exp=%b", name, e, all_ready, e >= D[N-1]);
      end
      total++;
      if (timeout_err !== eerr) begin
        bad++; $display("FAIL %s timeout_err e=%0d got=%b exp=%b", name, e, timeout_err, eerr);
      end
      total++;
      if (fault_stage !== 3'(ef)) begin
        bad++; $display("FAIL %s fault_stage e=%0d got=%0d exp=%0d", name, e, fault_stage, ef);
      end
    end
  endtask

  task automatic pulse_req;
    reset_req = 1;
    @(posedge clock); #1;
    reset_req = 0;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clock);
    #1;
    total++;
    if ({stage_reset, all_ready, timeout_err, fault_stage} !== {{N{1'b1}}, 5'b0}) begin
      bad++;
      $display("FAIL reset got sr=%b rdy=%b err=%b fs=%0d exp sr=1111 rdy=0 err=0 fs=0",
               stage_reset, all_ready, timeout_err, fault_stage);
    end
    reset = 0;
  endtask

  task automatic test_basic;
    a = '{5, 5, 5, 5};
    run_seq("basic", -1);
    total++;
    if (timeout_err !== 1'b0 || all_ready !== 1'b1) begin
      bad++; $display("FAIL basic_end got err=%b rdy=%b exp err=0 rdy=1", timeout_err, all_ready);
    end
  endtask

  task automatic test_timeout;
    pulse_req();
    a = '{1, 0, 1, 1};
    run_seq("timeout", -1);
    total++;
    if (timeout_err !== 1'b1 || fault_stage !== 3'd1 || all_ready !== 1'b1) begin
      bad++;
      $display("FAIL timeout_end got err=%b fs=%0d rdy=%b exp err=1 fs=1 rdy=1",
               timeout_err, fault_stage, all_ready);
    end
  endtask

  task automatic test_abort;
    pulse_req();
    a = '{1, 0, 0, 1};
    plan(cyc + 1);
    run_seq("abort", R[2] + 2);
    a = '{2, 1, 3, 1};
    run_seq("abort_reseq", -1);
    total++;
    if (all_ready !== 1'b1 || timeout_err !== 1'b0) begin
      bad++; $display("FAIL abort_reseq_end got rdy=%b err=%b exp rdy=1 err=0", all_ready, timeout_err);
    end
  endtask

  task automatic test_collision;
    pulse_req();
    a = '{1, 1, 1, 1};
    plan(cyc + 1);
    a[0] = (R[0] / DIV + 1) * DIV + DIV * (TMO - 1) - R[0];
    run_seq("collision", -1);
    total++;
    if (timeout_err !== 1'b0 || stage_reset[1] !== 1'b0) begin
      bad++; $display("FAIL collision_end got err=%b sr1=%b exp err=0 sr1=0", timeout_err, stage_reset[1]);
    end
  endtask

  task automatic test_hold_ext;
    reset_req = 1;
    for (int i = 0; i < 50; i++) begin
      stage_ack = 4'($urandom);
      @(posedge clock); #1;
      total++;
      if (stage_reset !== '1 || all_ready !== 1'b0) begin
        bad++; $display("FAIL hold_ext i=%0d got sr=%b rdy=%b exp sr=1111 rdy=0", i, stage_reset, all_ready);
      end
    end
    reset_req = 0;
    stage_ack = '0;
    a = '{3, 2, 1, 4};
    run_seq("hold_ext_release", -1);
  endtask

  task automatic test_reset_priority;
    pulse_req();
    a = '{1, 1, 0, 2};
    run_seq("prio_setup", -1);
    total++;
    if (timeout_err !== 1'b1) begin
      bad++; $display("FAIL prio_setup_err got=%b exp=1", timeout_err);
    end
    reset = 1;
    @(posedge clock); #1;
    reset = 0;
    total++;
    if ({stage_reset, all_ready, timeout_err, fault_stage} !== {{N{1'b1}}, 5'b0}) begin
      bad++;
      $display("FAIL prio_reset got sr=%b rdy=%b err=%b fs=%0d exp sr=1111 rdy=0 err=0 fs=0",
               stage_reset, all_ready, timeout_err, fault_stage);
    end
    a = '{4, 4, 4, 4};
    run_seq("prio_restart", -1);
  endtask

  task automatic test_random;
    for (int it = 0; it < 15; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        reset = 1;
        @(posedge clock); #1;
        reset = 0;
      end else begin
        pulse_req();
        total++;
        if ({stage_reset, all_ready, timeout_err, fault_stage} !== {{N{1'b1}}, 5'b0}) begin
          bad++;
          $display("FAIL rand_pulse it=%0d got sr=%b rdy=%b err=%b fs=%0d exp sr=1111 rdy=0 err=0 fs=0",
                   it, stage_reset, all_ready, timeout_err, fault_stage);
        end
      end
      for (int k = 0; k < N; k++) a[k] = $urandom_range(0, 13);
      if ($urandom_range(0, 2) == 0) begin
        plan(cyc + 1);
        run_seq("rand_abort", R[0] + $urandom_range(0, D[N-1] - R[0]));
        for (int k = 0; k < N; k++) a[k] = $urandom_range(0, 13);
      end
      run_seq("rand", -1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_abort();
    test_collision();
    test_hold_ext();
    test_reset_priority();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Consumes the system reset request produced by the keyboard's power-on / Fn-long-press reset logic and turns it into an ordered, per-subsystem reset release. All stage resets assert together. Stages then release one at a time; each stage must acknowledge initialisation, or time out, before the next stage releases. The block sits between the reset request source and the scan, debounce, report and host-interface subsystems.

## Interface
- STAGES, 4: number of sequenced reset stages (1–8).
- TICK_DIV, 65536: clock cycles per timing tick (≥2).
- HOLD_TICKS, 2: ticks all stages stay in reset after `reset_req` deasserts (≥1).
- ACK_TIMEOUT, 255: ticks to wait for a stage ack before flagging timeout (1–255).
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  block reset, synchronous, active-high.
- reset_req  in  1  level reset request from the reset controller; high = hold everything in reset.
- stage_ack  in  STAGES  per-stage "init done" level, sampled synchronously.
- stage_reset  out  STAGES  per-stage reset, active-high; bit 0 releases first.
- all_ready  out  1  high once every stage has been released and acked or timed out.
- timeout_err  out  1  sticky; set if any stage timed out since the last `reset_req` or `reset`.
- fault_stage  out  3  index of the first stage that timed out; 0 if none.

## Operation
- Prescaler: the counter runs 0..TICK_DIV-1 and wraps. `tick` is a 1-cycle pulse when the count equals TICK_DIV-1. The prescaler runs freely in every state and is cleared only by `reset`.
- States: HOLD, RELEASE, WAIT_ACK, READY.
- HOLD
  - All `stage_reset` bits are 1. The tick counter is cleared while `reset_req` = 1.
  - With `reset_req` = 0, the tick counter increments per tick. On reaching HOLD_TICKS, the FSM goes to RELEASE with idx = 0.
- RELEASE
  - Clears `stage_reset[idx]`, clears the tick counter, then goes to WAIT_ACK. Lasts 1 cycle.
- WAIT_ACK
  - `stage_ack[idx]` = 1: advance. If idx = STAGES-1, go to READY; otherwise idx+1 and RELEASE.
  - Otherwise, the tick counter increments per tick. On reaching ACK_TIMEOUT, set `timeout_err`. If this is the first timeout, load `fault_stage` = idx. Then advance exactly as for an ack.
  - Ack and timeout in the same cycle: ack wins; no error is recorded.
- READY
  - `all_ready` = 1. Later changes on `stage_ack` are ignored.
- `reset_req` = 1 in any state (priority over everything except `reset`):
  - Next edge: FSM to HOLD, all `stage_reset` = 1, `all_ready` = 0.
  - `timeout_err` and `fault_stage` cleared; idx and tick counter cleared.
- Released stages stay released (bit 0) until the next `reset_req` or `reset`; bits above idx stay 1.
- Counters: the tick counter is 8 bits and saturates, never wraps. idx width is 3 bits.

## Timing
- `reset` high at an edge, with values registered on that edge:
  - FSM = HOLD; `stage_reset` = all 1; `all_ready` = 0; `timeout_err` = 0; `fault_stage` = 0; prescaler, tick counter and idx = 0.
- Outputs are registered; no combinational input-to-output path.
- `reset_req` rise at edge N: `stage_reset` is all 1 and `all_ready` is 0 after edge N+1.
- HOLD exit happens on the edge at which the HOLD_TICKS-th tick after `reset_req` fell is counted. `stage_reset[0]` falls 1 cycle later (RELEASE).
- An ack that is high during the first WAIT_ACK cycle advances on that edge. The minimum release spacing between consecutive stages is therefore 2 cycles.
- `all_ready` rises on the edge following the last stage's ack or timeout decision.
- A `reset_req` pulse of one cycle is honoured fully; HOLD always lasts ≥ HOLD_TICKS ticks.

## Test plan
- Test configuration for all scenarios: TICK_DIV=4, HOLD_TICKS=2, ACK_TIMEOUT=3, STAGES=4.
- Basic sequence:
  - Stimulus: `reset` 1 cycle; `reset_req` = 0; each `stage_ack` tied high 5 cycles after its release.
  - Required: `stage_reset` goes 1111→1110→1100→1000→0000, in order, with stable spacing.
  - Required: `all_ready` = 1 one cycle after the stage-3 ack; `timeout_err` = 0.
- Timeout:
  - Stimulus: `stage_ack[1]` held 0; other stages ack immediately.
  - Required: stage 2 releases after 3 ticks (~12 cycles) in WAIT_ACK.
  - Required: `timeout_err` = 1, `fault_stage` = 1, `all_ready` = 1 at the end.
- Abort mid-sequence:
  - Stimulus: assert `reset_req` for 1 cycle while in WAIT_ACK for stage 2.
  - Required: `stage_reset` = 1111 and `all_ready` = 0 after the next edge; errors cleared.
  - Required: full re-sequence after 2 ticks of HOLD.
- Ack/timeout collision:
  - Stimulus: raise `stage_ack[0]` exactly on the cycle the 3rd tick is counted.
  - Required: `timeout_err` stays 0 and stage 1 releases.
- Hold extension:
  - Stimulus: `reset_req` held high for 50 cycles.
  - Required: `stage_reset` = 1111 throughout. After the fall, `stage_reset[0]` clears 1 cycle after the 2nd subsequent tick (5–9 cycles).
- Reset priority:
  - Stimulus: assert `reset` in READY with `timeout_err` = 1.
  - Required: all outputs return to reset values on that edge, and the sequence restarts.
